// File: rtl/audit_counter_poller_if.sv
// AXI-Lite read-channel bundle between the audit counter poller (master) and the
// bus audit hook's status slave.
`timescale 1ns/1ps

interface audit_counter_poller_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/audit_counter_poller.sv
// Periodic tear-free poller of the 64-bit audit event counter, with delta/threshold irq.
// Optional handshake watchdog enabled by defining AUDIT_POLL_TIMEOUT_EN.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for interval timer expiry or poll_req
// AR     | read address presented for the current phase
// R      | waiting for read data of the current phase
// EVAL   | commit snapshot, compute delta, update irq
module audit_counter_poller #(
    parameter int unsigned POLL_INTERVAL   = 1024,
    parameter logic [63:0] DELTA_THRESHOLD = 64'd1,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          poll_req,
    input  logic                          irq_clear,
    audit_counter_poller_if.master        m_axil,
    output logic [63:0]                   snapshot,
    output logic                          snapshot_valid,
    output logic [63:0]                   delta,
    output logic                          irq,
    output logic [15:0]                   err_count,
    output logic                          busy
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_EVAL} state_t;

    localparam logic [1:0]  PH_HI0 = 2'd0;
    localparam logic [1:0]  PH_LO  = 2'd1;
    localparam logic [1:0]  PH_HI1 = 2'd2;
    localparam logic [20:0] INTERVAL_LOAD  = 21'(POLL_INTERVAL - 1);
    localparam logic [20:0] INTERVAL_FIRST = (POLL_INTERVAL > 1) ? 21'(POLL_INTERVAL - 2) : 21'd0;

    if (POLL_INTERVAL < 1 || POLL_INTERVAL > (1 << 20)) begin : g_bad_interval
        $error("POLL_INTERVAL out of range 1..2^20");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state, state_next;
    logic [1:0]  phase, phase_next;
    logic [31:0] hi_word, lo_word;
    logic [20:0] timer;
    logic        primed;
    logic        abort, expired, wd_expired;
    logic        ar_hs, r_hs, r_ok;
    logic [63:0] new_value, new_delta;

    assign ar_hs     = m_axil.arvalid && m_axil.arready;
    assign r_hs      = m_axil.rvalid && m_axil.rready;
    assign r_ok      = r_hs && (m_axil.rresp == 2'b00);
    // The first idle stretch after reset has one cycle spent priming the timer.
    assign expired   = primed ? (timer == 21'd0) : (POLL_INTERVAL == 1);
    assign new_value = {hi_word, lo_word};
    assign new_delta = new_value - snapshot;

    always_comb begin
        state_next = state;
        phase_next = phase;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (expired || poll_req) begin
                    state_next = S_AR;
                    phase_next = PH_HI0;
                end
            end
            S_AR: begin
                if (ar_hs)
                    state_next = S_R;
                else if (wd_expired)
                    abort = 1'b1;
            end
            S_R: begin
                if (r_hs && !r_ok) begin
                    abort = 1'b1;
                end else if (r_ok) begin
                    state_next = S_AR;
                    case (phase)
                        PH_HI0:  phase_next = PH_LO;
                        PH_LO:   phase_next = PH_HI1;
                        default: begin
                            if (m_axil.rdata == hi_word)
                                state_next = S_EVAL;
                            else
                                phase_next = PH_LO;
                        end
                    endcase
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            S_EVAL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            phase          <= PH_HI0;
            m_axil.araddr  <= 32'd0;
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            phase          <= phase_next;
            m_axil.arvalid <= (state_next == S_AR);
            m_axil.rready  <= (state_next == S_R);
            busy           <= (state_next != S_IDLE);
            if (state_next == S_AR)
                m_axil.araddr <= (phase_next == PH_LO) ? BASE_ADDR : BASE_ADDR + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer  <= 21'd0;
            primed <= 1'b0;
        end else if (state_next == S_IDLE && state != S_IDLE) begin
            timer <= INTERVAL_LOAD;
        end else if (state == S_IDLE) begin
            if (!primed) begin
                primed <= 1'b1;
                timer  <= INTERVAL_FIRST;
            end else if (timer != 21'd0) begin
                timer <= timer - 21'd1;
            end
        end
    end

    // hi_word always holds the most recent HI read, so a matching HI1 leaves it valid for commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_word <= 32'd0;
            lo_word <= 32'd0;
        end else if (state == S_R && r_ok) begin
            if (phase == PH_LO)
                lo_word <= m_axil.rdata;
            else
                hi_word <= m_axil.rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot       <= 64'd0;
            delta          <= 64'd0;
            snapshot_valid <= 1'b0;
            irq            <= 1'b0;
            err_count      <= 16'd0;
        end else begin
            snapshot_valid <= (state == S_EVAL);
            if (state == S_EVAL) begin
                snapshot <= new_value;
                delta    <= new_delta;
            end
            if (state == S_EVAL && new_delta >= DELTA_THRESHOLD)
                irq <= 1'b1;
            else if (irq_clear)
                irq <= 1'b0;
            if (abort && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

`ifdef AUDIT_POLL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd <= '0;
        else if (state_next != state)
            wd <= WD_W'(TIMEOUT_CYCLES - 1);
        else if (wd != '0)
            wd <= wd - 1'b1;
    end

    assign wd_expired = (wd == '0);
`else
    assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_audit_counter_poller.sv
// Directed bench for audit_counter_poller against a scripted AXI-Lite counter slave.
`timescale 1ns/1ps

module tb_audit_counter_poller;
    localparam int unsigned POLL_INTERVAL = 16;
    localparam logic [63:0] THRESH        = 64'd4;
    localparam int unsigned TIMEOUT       = 8;
    localparam int unsigned NEVER         = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        poll_req = 1'b0;
    logic        irq_clear = 1'b0;
    logic [63:0] snapshot, delta;
    logic        snapshot_valid, irq, busy;
    logic [15:0] err_count;

    audit_counter_poller_if axil();

    audit_counter_poller #(
        .POLL_INTERVAL  (POLL_INTERVAL),
        .DELTA_THRESHOLD(THRESH),
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .poll_req      (poll_req),
        .irq_clear     (irq_clear),
        .m_axil        (axil),
        .snapshot      (snapshot),
        .snapshot_valid(snapshot_valid),
        .delta         (delta),
        .irq           (irq),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Slave: counter value cnt, switching to roll_val for reads after index roll_at.
    logic [63:0] cnt = 64'd0;
    logic [63:0] roll_val = 64'd0;
    int unsigned roll_at = NEVER;
    int unsigned err_idx = NEVER;
    int unsigned rd_cnt = 0;
    logic [31:0] addr_log [0:255];

    function automatic logic [31:0] slave_word(input logic [31:0] a, input int unsigned idx);
        logic [63:0] v;
        v = (idx > roll_at) ? roll_val : cnt;
        return a[2] ? v[63:32] : v[31:0];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axil.rvalid <= 1'b0;
            axil.rdata  <= 32'd0;
            axil.rresp  <= 2'b00;
        end else begin
            if (axil.rvalid && axil.rready)
                axil.rvalid <= 1'b0;
            if (axil.arvalid && axil.arready) begin
                addr_log[rd_cnt[7:0]] <= axil.araddr;
                axil.rdata  <= slave_word(axil.araddr, rd_cnt);
                axil.rresp  <= (rd_cnt == err_idx) ? 2'b10 : 2'b00;
                axil.rvalid <= 1'b1;
                rd_cnt      <= rd_cnt + 1;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arvalid(output int n);
        n = 0;
        while (!axil.arvalid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_sv(input string tag, output int n);
        n = 0;
        while (!snapshot_valid && n < 200) begin
            tick();
            n++;
        end
        if (!snapshot_valid)
            chk({tag, "_timeout"}, {63'd0, snapshot_valid}, 64'd1);
    endtask

    task automatic do_poll_req(input string tag);
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic pulse_irq_clear(input string tag);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk({tag, "_irq_cleared"}, {63'd0, irq}, 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_araddr"},  {32'd0, axil.araddr}, 64'd0);
        chk({tag, "_arvalid"}, {63'd0, axil.arvalid}, 64'd0);
        chk({tag, "_rready"},  {63'd0, axil.rready}, 64'd0);
        chk({tag, "_snap"},    snapshot, 64'd0);
        chk({tag, "_delta"},   delta, 64'd0);
        chk({tag, "_sv"},      {63'd0, snapshot_valid}, 64'd0);
        chk({tag, "_irq"},     {63'd0, irq}, 64'd0);
        chk({tag, "_err"},     {48'd0, err_count}, 64'd0);
        chk({tag, "_busy"},    {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n;
        int unsigned base;
        axil.arready = 1'b1;
        cnt = 64'h0000_0001_0000_0005;

        // Reset state and first poll after release
        repeat (3) tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        base = rd_cnt;
        wait_arvalid(n);
        chk("first_poll_delay", n, POLL_INTERVAL);
        chk("first_araddr", {32'd0, axil.araddr}, 64'h4);
        wait_sv("basic", n);
        chk("latency", n, 7);
        chk("basic_nreads", rd_cnt - base, 3);
        chk("basic_addr0", {32'd0, addr_log[base[7:0]]}, 64'h4);
        chk("basic_addr1", {32'd0, addr_log[8'(base + 1)]}, 64'h0);
        chk("basic_addr2", {32'd0, addr_log[8'(base + 2)]}, 64'h4);
        chk("basic_snap", snapshot, 64'h0000_0001_0000_0005);
        chk("basic_delta", delta, 64'h0000_0001_0000_0005);
        chk("basic_irq", {63'd0, irq}, 64'd1);
        tick();
        chk("sv_one_pulse", {63'd0, snapshot_valid}, 64'd0);
        pulse_irq_clear("basic");

        // Carry between LO and HI1 forces a re-read
        cnt      = 64'h0000_0000_FFFF_FFFF;
        roll_val = 64'h0000_0001_0000_0000;
        base     = rd_cnt;
        roll_at  = base + 1;
        do_poll_req("carry");
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
        wait_sv("carry", n);
        chk("carry_snap", snapshot, 64'h0000_0001_0000_0000);
        chk("carry_delta", delta, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("carry_nreads", rd_cnt - base, 5);
        chk("carry_addr3", {32'd0, addr_log[8'(base + 3)]}, 64'h0);
        chk("carry_addr4", {32'd0, addr_log[8'(base + 4)]}, 64'h4);
        wait_arvalid(n);
        chk("no_queued_req", n, POLL_INTERVAL);
        cnt     = 64'h0000_0001_0000_0000;
        roll_at = NEVER;
        wait_sv("zero", n);
        chk("zero_delta", delta, 64'd0);
        pulse_irq_clear("zero");

        // Wrap modulo 2^64 and threshold boundary
        cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        do_poll_req("wrap0");
        wait_sv("wrap0", n);
        chk("wrap0_snap", snapshot, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap0_delta", delta, 64'hFFFF_FFFE_FFFF_FFFE);
        pulse_irq_clear("wrap0");
        cnt = 64'd1;
        do_poll_req("wrap1");
        wait_sv("wrap1", n);
        chk("wrap1_delta", delta, 64'd3);
        chk("wrap1_irq", {63'd0, irq}, 64'd0);
        cnt = 64'd5;
        irq_clear = 1'b1;
        do_poll_req("thr");
        wait_sv("thr", n);
        irq_clear = 1'b0;
        chk("thr_delta", delta, 64'd4);
        chk("set_wins_irq", {63'd0, irq}, 64'd1);

        // Error response on the LO read
        cnt     = 64'd9;
        base    = rd_cnt;
        err_idx = base + 1;
        do_poll_req("err");
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        err_idx = NEVER;
        chk("err_idle", {63'd0, busy}, 64'd0);
        chk("err_count1", {48'd0, err_count}, 64'd1);
        chk("err_snap", snapshot, 64'd5);
        chk("err_delta", delta, 64'd4);
        wait_sv("after_err", n);
        chk("after_err_snap", snapshot, 64'd9);
        chk("after_err_delta", delta, 64'd4);

        // Slave never accepts the address
        axil.arready = 1'b0;
        do_poll_req("stall");
`ifdef AUDIT_POLL_TIMEOUT_EN
        n = 0;
        while (axil.arvalid && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_err", {48'd0, err_count}, 64'd2);
        chk("timeout_idle", {63'd0, busy}, 64'd0);
`else
        repeat (40) tick();
        chk("stall_arvalid", {63'd0, axil.arvalid}, 64'd1);
        chk("stall_busy", {63'd0, busy}, 64'd1);
        chk("stall_err", {48'd0, err_count}, 64'd1);
`endif
        axil.arready = 1'b1;

        // Asynchronous reset while in R with data pending
        n = 0;
        while (!axil.rready && n < 100) begin
            tick();
            n++;
        end
        chk("reach_r", {63'd0, axil.rready}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        tick();
        reset_n = 1'b1;
        wait_arvalid(n);
        chk("rst_poll_delay", n, POLL_INTERVAL);
        chk("rst_araddr", {32'd0, axil.araddr}, 64'h4);
        wait_sv("rst", n);
        chk("rst_snap", snapshot, 64'd9);
        chk("rst_delta", delta, 64'd9);
        chk("rst_irq", {63'd0, irq}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
